// File: rtl/dsm_demod.sv
// dsm_demod: decodes 3-level pwm symbols, optionally mixes with a 4-phase LO, and decimates with a 3rd-order CIC.
// Optional mixer is enabled by defining DSM_DEMOD_MIX_EN; without it the CIC decimates the baseband symbols.
module dsm_demod #(
  parameter int DEC_LOG2 = 6
`ifdef DSM_DEMOD_MIX_EN
  , parameter int LO_PHASE = 0
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sync_clr,
  input  logic [1:0]  pwm,
  output logic [19:0] dout,
  output logic        dout_valid,
  output logic        sym_err
);

  localparam int W = 2 + 3 * DEC_LOG2;
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [DEC_LOG2-1:0] DEC_LAST = {DEC_LOG2{1'b1}};
  localparam logic [DEC_LOG2-1:0] DEC_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};

  // Symbol code to signed level; the illegal code contributes nothing.
  function automatic logic signed [1:0] decode_sym(input logic [1:0] code);
    logic signed [1:0] lvl;
    case (code)
      2'b01:   lvl = 2'sb01;
      2'b10:   lvl = 2'sb11;
      default: lvl = 2'sb00;
    endcase
    return lvl;
  endfunction

  logic signed [1:0]   sym_s;
  logic signed [1:0]   mix_s;
  logic [W-1:0]        m_ext_s;
  logic [W-1:0]        i3_next_s;
  logic                tick_s;
  logic [W-1:0]        c3_s;
  logic [19:0]         scaled_s;

  logic [W-1:0]        i1_r;
  logic [W-1:0]        i2_r;
  logic [W-1:0]        i3_r;
  logic [DEC_LOG2-1:0] dec_cnt_r;
  logic [W-1:0]        cap_r;
  logic [W-1:0]        cap_dly_r;
  logic [W-1:0]        c1_r;
  logic [W-1:0]        c1_dly_r;
  logic [W-1:0]        c2_r;
  logic [W-1:0]        c2_dly_r;
  logic                v0_r;
  logic                v1_r;
  logic                v2_r;

  assign sym_s = decode_sym(pwm);

`ifdef DSM_DEMOD_MIX_EN
  logic [1:0] lo_cnt_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_cnt_r <= 2'(LO_PHASE);
    end else if (sync_clr) begin
      lo_cnt_r <= 2'(LO_PHASE);
    end else begin
      lo_cnt_r <= lo_cnt_r + 2'd1;
    end
  end

  // LO sequence +1, 0, -1, 0 applied to the decoded symbol.
  always_comb begin
    mix_s = 2'sb00;
    case (lo_cnt_r)
      2'd0:    mix_s = sym_s;
      2'd2:    mix_s = 2'sb00 - sym_s;
      default: mix_s = 2'sb00;
    endcase
  end
`else
  assign mix_s = sym_s;
`endif

  assign m_ext_s   = {{(W-2){mix_s[1]}}, mix_s};
  assign i3_next_s = i3_r + i2_r;
  assign tick_s    = (dec_cnt_r == DEC_LAST);
  assign c3_s      = c2_r - c2_dly_r;

  generate
    if (W >= 20) begin : g_trunc
      assign scaled_s = c3_s[W-1 -: 20];
    end else begin : g_shift
      assign scaled_s = {c3_s, {(20-W){1'b0}}};
    end
  endgenerate

  // Integrators wrap modulo 2^W by design; the combs undo the wrap exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i1_r      <= ZERO_W;
      i2_r      <= ZERO_W;
      i3_r      <= ZERO_W;
      dec_cnt_r <= {DEC_LOG2{1'b0}};
    end else if (sync_clr) begin
      i1_r      <= ZERO_W;
      i2_r      <= ZERO_W;
      i3_r      <= ZERO_W;
      dec_cnt_r <= {DEC_LOG2{1'b0}};
    end else begin
      i1_r      <= i1_r + m_ext_s;
      i2_r      <= i2_r + i1_r;
      i3_r      <= i3_next_s;
      dec_cnt_r <= dec_cnt_r + DEC_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_r     <= ZERO_W;
      cap_dly_r <= ZERO_W;
      c1_r      <= ZERO_W;
      c1_dly_r  <= ZERO_W;
      c2_r      <= ZERO_W;
      c2_dly_r  <= ZERO_W;
      v0_r      <= 1'b0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
    end else if (sync_clr) begin
      cap_r     <= ZERO_W;
      cap_dly_r <= ZERO_W;
      c1_r      <= ZERO_W;
      c1_dly_r  <= ZERO_W;
      c2_r      <= ZERO_W;
      c2_dly_r  <= ZERO_W;
      v0_r      <= 1'b0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
    end else begin
      v0_r <= tick_s;
      v1_r <= v0_r;
      v2_r <= v1_r;
      if (tick_s) begin
        cap_r <= i3_next_s;
      end else begin
        cap_r <= cap_r;
      end
      // Each comb delay element advances only on a decimated sample.
      if (v0_r) begin
        c1_r      <= cap_r - cap_dly_r;
        cap_dly_r <= cap_r;
      end else begin
        c1_r      <= c1_r;
        cap_dly_r <= cap_dly_r;
      end
      if (v1_r) begin
        c2_r     <= c1_r - c1_dly_r;
        c1_dly_r <= c1_r;
      end else begin
        c2_r     <= c2_r;
        c1_dly_r <= c1_dly_r;
      end
      if (v2_r) begin
        c2_dly_r <= c2_r;
      end else begin
        c2_dly_r <= c2_dly_r;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout       <= 20'd0;
      dout_valid <= 1'b0;
    end else if (sync_clr) begin
      dout       <= 20'd0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= v2_r;
      if (v2_r) begin
        dout <= scaled_s;
      end else begin
        dout <= dout;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sym_err <= 1'b0;
    end else if (sync_clr) begin
      sym_err <= 1'b0;
    end else if (pwm == 2'b11) begin
      sym_err <= 1'b1;
    end else begin
      sym_err <= sym_err;
    end
  end

endmodule

// File: doc/dsm_demod.md
Name: dsm_demod

Overview:
- Receive-side counterpart of the transmit DSM chain: it closes the loop on the 2-bit modulator output.
- Decodes the 3-level pwm symbol stream and mixes it back down with the same 4-phase LO sequence (+1, 0, -1, 0).
- Decimates with a 3rd-order CIC filter and delivers a 20-bit signed sample with a valid strobe.
- Used as the loopback/monitor path in bench and on-chip self-test of the modulator.

Parameters:
- DEC_LOG2, 6, log2 of the decimation ratio R; legal range 4..8; R = 2^DEC_LOG2.
- LO_PHASE, 0, initial LO counter value (0..3) after reset/sync_clr; aligns the demod LO to the transmit LO.

Ports:
- clock  in  1  system clock; one pwm symbol per cycle.
- reset  in  1  asynchronous, active-high reset.
- sync_clr  in  1  synchronous clear of all datapath state and counters; higher priority than normal operation.
- pwm  in  2  modulator symbol: 2'b01 = +1, 2'b00 = 0, 2'b10 = -1, 2'b11 = illegal.
- dout  out  20  decimated signed (two's complement) output sample.
- dout_valid  out  1  one-cycle pulse when dout updates.
- sym_err  out  1  sticky flag: an illegal symbol was received.

Behaviour:
- Reset: all outputs and internal state go to 0, except lo_cnt, which goes to LO_PHASE.
  - Reset acts asynchronously at any time, including mid-decimation or mid-comb-pipeline; no partial output is produced afterwards.
- sync_clr is sampled each clock edge and has the same effect as reset, but synchronously. It also clears sym_err.
- Symbol decode: s = +1 / 0 / -1 per the encoding above. 2'b11 decodes as s = 0 and sets sym_err.
- LO: 2-bit lo_cnt increments every cycle and wraps 3 -> 0. lo = +1 at cnt 0, 0 at cnt 1, -1 at cnt 2, 0 at cnt 3.
- Mix: m = s * lo, in the range -1..+1, sign-extended to internal width W = 2 + 3*DEC_LOG2.
- Integrators: three cascaded W-bit accumulators, updated every cycle.
  - I1 += m; I2 += I1; I3 += I2, all using values registered from the previous cycle.
  - Modular wrap-around is intentional and required; no saturation anywhere inside the CIC.
- Decimation counter dec_cnt runs 0..R-1 and wraps. The tick is dec_cnt == R-1.
  - On the tick in cycle k, I3 (as registered at the end of cycle k) is captured into the comb pipeline.
- Combs: three registered comb stages, C_n = x - x_delayed, each with a differential delay of one decimated sample.
  - Stages advance at k+1, k+2 and k+3.
  - dout and dout_valid are registered at k+3, so latency is 3 cycles from the tick. dout_valid is high for exactly one cycle.
- Output scaling:
  - If W >= 20: dout = comb result bits [W-1 : W-20].
  - If W < 20: dout = comb result shifted left by 20-W.
  - With DEC_LOG2 = 6, W = 20 and dout is the full result.
- Transient: the first 3 dout_valid outputs after reset/sync_clr are filter fill and are not checked. From the 4th onward, output equals R^3 * mean(m) over the last 3R inputs (CIC response).
- sync_clr and a tick in the same cycle: sync_clr wins; no capture, no dout_valid.

Optional Feature:
- Macro DSM_DEMOD_MIX_EN.
- Defined: the mixer is active as described above.
- Undefined: the mixer is bypassed, so m = s (baseband decimation only), and lo_cnt and LO_PHASE are unused and removed. Used for direct modulator testing without the LO.

Test Plan:
- reset held 5 cycles, then released with pwm = 00 -> dout = 0, sym_err = 0, dout_valid pulses exactly every 64 cycles.
- MIX_EN on, DEC_LOG2 = 6, LO_PHASE = 0; after sync_clr drive pwm = 01, 00, 10, 00 repeating, in phase with lo_cnt -> from the 4th valid onward dout = 131072 (0x20000).
- MIX_EN on, constant pwm = 01 -> steady-state dout = 0.
- MIX_EN off, constant pwm = 10 -> steady-state dout = -262144 (0xC0000); constant 01 -> 262144 (0x40000).
- pwm = 11 for one cycle inside a zero stream -> sym_err goes to 1 and stays 1; dout stays 0; sym_err clears one cycle after sync_clr.
- Assert reset asynchronously between clock edges, 2 cycles after a tick -> dout and dout_valid go to 0 immediately, with no pending dout_valid afterwards. Assert sync_clr together with a tick -> no dout_valid.
